// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
package alu_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned MULDIV_BIT = 0;

   // funct3 codes for the base integer ALU ops
   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_WB_FULL = 2'd2
   } state_e;

   // Control fields of one issued ALU instruction
   typedef struct packed {
      logic       is_alu;
      logic       is_imm;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] rd;
   } alu_ctl_t;

   // Reg-reg op with the M-extension funct7 bit set
   function automatic logic is_muldiv(input logic is_alu, input logic [6:0] funct7);
      return is_alu && funct7[MULDIV_BIT];
   endfunction

endpackage

// File: rtl/alu_issue.sv
// Issue-side controller for RiscVAlu: holds one decoded op on the ALU inputs
// until the ALU stops waiting, then hands the result to a writeback slot.
// Optional feature macro: MULTIPLY_EN (muldiv ops issued, alu_wait honoured,
// result side register built).
module alu_issue #(
   parameter int unsigned XLEN  = alu_pkg::XLEN,
   parameter int unsigned CNT_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_op_alu,
   input  logic              in_is_op_alu_imm,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   input  logic [XLEN-1:0]   in_imm,
   output logic              alu_enabled,
   output logic              alu_is_op_alu,
   output logic              alu_is_op_alu_imm,
   output logic [2:0]        alu_funct3,
   output logic [6:0]        alu_funct7,
   output logic [XLEN-1:0]   alu_s1,
   output logic [XLEN-1:0]   alu_s2,
   output logic [XLEN-1:0]   alu_imm,
   input  logic [XLEN-1:0]   alu_rd,
   input  logic              alu_wait,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              illegal,
   output logic [CNT_W-1:0]  stall_cycles
);
   import alu_pkg::*;

   state_e            r_state;
   alu_ctl_t          r_ctl;
   logic [XLEN-1:0]   r_s1;
   logic [XLEN-1:0]   r_s2;
   logic [XLEN-1:0]   r_imm;
   logic              r_drive;
   logic              r_wb_valid;
   logic [4:0]        r_wb_rd;
   logic [XLEN-1:0]   r_wb_data;
   logic              r_illegal;
   logic [CNT_W-1:0]  r_stall;

   logic              w_op_valid;
   logic              w_wait;
   logic              w_legal;
   logic              w_res_valid;
   logic [XLEN-1:0]   w_res_data;
   logic              w_res_valid_nx;
   logic              w_slot_free;
   logic              w_complete;
   logic              w_rd_zero;
   logic              w_retire;
   logic              w_wb_load;
   logic              w_park;
   logic              w_accept;
   logic              w_load;
   logic              w_wb_valid_nx;
   logic              w_op_valid_nx;
   logic [XLEN-1:0]   w_wb_data_nx;

`ifdef MULTIPLY_EN
   logic              r_res_valid;
   logic [XLEN-1:0]   r_res_data;

   assign w_legal     = in_is_op_alu || in_is_op_alu_imm;
   assign w_wait      = alu_wait;
   assign w_res_valid = r_res_valid;
   assign w_res_data  = r_res_data;
   assign w_park      = w_complete && !w_rd_zero && !w_slot_free;
   assign w_res_valid_nx = w_park || (w_res_valid && !w_retire);

   // Side register: park a finished result so the ALU inputs can drop to zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_res_valid <= w_res_valid_nx;
         if (w_park) r_res_data <= alu_rd;
      end
   end
`else
   logic              w_unused;

   assign w_legal     = (in_is_op_alu || in_is_op_alu_imm) &&
                        !is_muldiv(in_is_op_alu, in_funct7);
   assign w_wait      = 1'b0;
   assign w_res_valid = 1'b0;
   assign w_res_data  = '0;
   assign w_park      = 1'b0;
   assign w_res_valid_nx = 1'b0;
   assign w_unused    = alu_wait;
`endif

   assign w_op_valid  = (r_state == ST_EXEC);
   assign w_slot_free = !r_wb_valid || wb_ready;
   assign w_complete  = w_op_valid && !w_res_valid && !w_wait;
   assign w_rd_zero   = (r_ctl.rd == 5'd0);

   // A result leaves the op stage either straight from the ALU or from the side register
   assign w_wb_load   = w_op_valid && !w_rd_zero && w_slot_free && (w_complete || w_res_valid);
   assign w_retire    = (w_complete && (w_rd_zero || w_slot_free)) ||
                        (w_op_valid && w_res_valid && w_slot_free);
   assign w_wb_data_nx = w_res_valid ? w_res_data : alu_rd;

   assign in_ready    = !w_op_valid || (w_complete && w_slot_free && !w_res_valid);
   assign w_accept    = in_valid && in_ready;
   assign w_load      = w_accept && w_legal;

   assign w_wb_valid_nx = w_wb_load || (r_wb_valid && !wb_ready);
   assign w_op_valid_nx = w_load || (w_op_valid && !w_retire);

   // Operand stage FSM, writeback slot, illegal pulse and stall counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_ctl      <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
         r_imm      <= '0;
         r_drive    <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= 5'd0;
         r_wb_data  <= '0;
         r_illegal  <= 1'b0;
         r_stall    <= '0;
      end else begin
         r_illegal  <= w_accept && !w_legal;
         r_wb_valid <= w_wb_valid_nx;
         r_drive    <= w_op_valid_nx && !w_res_valid_nx;
         if (w_wait) r_stall <= r_stall + CNT_W'(1);
         if (w_wb_load) begin
            r_wb_rd   <= r_ctl.rd;
            r_wb_data <= w_wb_data_nx;
         end
         if (w_load) begin
            r_ctl <= alu_ctl_t'{is_alu: in_is_op_alu, is_imm: in_is_op_alu_imm,
                                funct3: in_funct3, funct7: in_funct7, rd: in_rd};
            r_s1  <= in_rs1;
            r_s2  <= in_rs2;
            r_imm <= in_imm;
         end
         if (w_op_valid_nx)      r_state <= ST_EXEC;
         else if (w_wb_valid_nx) r_state <= ST_WB_FULL;
         else                    r_state <= ST_IDLE;
      end
   end

   assign alu_enabled       = r_drive;
   assign alu_is_op_alu     = r_drive && r_ctl.is_alu;
   assign alu_is_op_alu_imm = r_drive && r_ctl.is_imm;
   assign alu_funct3        = r_drive ? r_ctl.funct3 : 3'd0;
   assign alu_funct7        = r_drive ? r_ctl.funct7 : 7'd0;
   assign alu_s1            = r_drive ? r_s1  : '0;
   assign alu_s2            = r_drive ? r_s2  : '0;
   assign alu_imm           = r_drive ? r_imm : '0;

   assign wb_valid     = r_wb_valid;
   assign wb_rd        = r_wb_rd;
   assign wb_data      = r_wb_data;
   assign illegal      = r_illegal;
   assign stall_cycles = r_stall;

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue-side controller for the ALU (`RiscVAlu`): accepts one decoded ALU instruction at a time from the decode stage through a valid/ready handshake. It holds the operands stable on the ALU inputs for as long as `is_alu_wait` is asserted, then captures `rd_alu` into a writeback register. Sits between decode and register-file writeback, and is the sole driver of the ALU's inputs.

## Interface
Parameters:
- XLEN, 32, operand/result width
- CNT_W, 32, width of stall counter

Ports (one clock; reset is asynchronous, active-high):
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted on this edge when in_valid
- in_is_op_alu / in_is_op_alu_imm  in  1  reg-reg / reg-imm ALU op
- in_funct3  in  3;  in_funct7  in  7;  in_rd  in  5
- in_rs1, in_rs2, in_imm  in  XLEN  operand values
- alu_enabled, alu_is_op_alu, alu_is_op_alu_imm  out  1  to ALU
- alu_funct3  out  3;  alu_funct7  out  7
- alu_s1, alu_s2, alu_imm  out  XLEN  to ALU
- alu_rd  in  XLEN  ALU result;  alu_wait  in  1  ALU is_alu_wait
- wb_valid  out  1;  wb_ready  in  1;  wb_rd  out  5;  wb_data  out  XLEN
- illegal  out  1  one-cycle pulse: rejected instruction
- stall_cycles  out  CNT_W  count of cycles with alu_wait high

## Operation
- Operand register (op_q, op_valid); writeback register (wb_q, wb_valid).
- FSM: IDLE (op_valid=0), EXEC (op_q driving ALU), WB_FULL (wb_valid=1 and op_valid=0).
- IDLE: all ALU outputs are 0 and alu_enabled=0. Accept on in_valid -> EXEC.
- EXEC: ALU outputs = op_q and alu_enabled=1. Outputs are constant while alu_wait=1; the ALU requires this.
- Completion is the cycle in EXEC with alu_wait=0. alu_rd is valid only then.
- On completion with the wb slot free (wb_valid=0, or wb_ready=1 this cycle): wb_q<=alu_rd, wb_rd<=op rd, wb_valid<=1.
- On completion with the wb slot blocked: remain in EXEC. With alu_wait=0 and inputs unchanged, a muldiv would restart in the ALU. The block therefore latches the result into a side register (res_q, res_valid) and drives ALU outputs to 0 until the wb slot frees.
- rd==0: on completion the result is discarded and wb_valid is not set.
- in_ready = !op_valid || (completion && slot free && !res_valid).
- Back-to-back: a new op loads on the completion edge. The ALU has already cleared its in_progress by then, so a new muldiv restarts cleanly.
- in_valid with neither is_op flag set: illegal pulse, consumed, no ALU activity.
- wb handshake: transfer when wb_valid && wb_ready. wb_valid, wb_rd and wb_data stay stable until transfer.
- stall_cycles increments each cycle alu_wait=1 and wraps at 2^CNT_W.

## Timing
- Reset: every output 0, except in_ready=1. FSM is IDLE, stall_cycles=0, res_valid=0.
- Reset mid-operation clears op_q, wb_q and res_q. The ALU shares the reset, so there is no stale state.
- Simple op: accepted edge N; ALU driven cycle N+1; wb_valid from edge N+2. Throughput is 1 per cycle with wb_ready=1.
- Muldiv: EXEC lasts 1 + k cycles, where k is the ALU's iteration count. wb_valid follows the first alu_wait=0 cycle.
- Zero operand: alu_wait is never raised, so latency equals a simple op.
- Simultaneous wb transfer and completion: the new result replaces the old one with no bubble.

## Configuration
- MULTIPLY_EN defined: ops with in_is_op_alu && in_funct7[0] are issued, and alu_wait is honoured.
- MULTIPLY_EN undefined:
  - such ops raise illegal and are dropped;
  - alu_wait is ignored (treated as 0) and stall_cycles stays 0;
  - res_q and res_valid are not built.

## Structure
- Shared package alu_pkg: FSM state enum, funct3 codes (ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, OR=6, AND=7), muldiv funct7 bit index 0, XLEN.
- No sub-module required. Optionally factor the wb register with its valid/ready logic as `wb_slot`.

## Test plan
- ADD: rs1=5, rs2=7, rd=3, wb_ready=1 -> wb_valid two cycles after accept, with wb_rd=3 and wb_data=12.
- MUL (MULTIPLY_EN): rs1=7, rs2=6, rd=4 -> operands stable for all alu_wait cycles; wb_data=42; stall_cycles equals the number of alu_wait-high cycles.
- Backpressure: wb_ready=0 during two ADDs (1+1, 2+2) -> first result held; second op parked in res_q; in_ready=0. Releasing wb_ready delivers 2 then 4 in order.
- rd=0: SUB 9-4 to rd=0 -> no wb_valid, in_ready returns high next cycle.
- Reset during DIVU 100/7: assert reset mid-wait -> all outputs 0 and in_ready=1. A fresh DIVU 100/7 then gives 14.
- MULTIPLY_EN undefined: MUL 3*3 -> illegal pulses one cycle, no wb_valid, ALU outputs stay 0.
